// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte scheduler that shares one uart transmitter and owns its baud config
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int BUSY_TIMEOUT = 4096,
  parameter logic [2:0] DEFAULT_BAUD = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  input  logic               cfg_wr,
  input  logic [2:0]         cfg_baud,
  output logic               cfg_pending,
  output logic               tx_en,
  output logic               tx_wr,
  output logic [7:0]         tx_data,
  output logic [2:0]         baud_select,
  input  logic               tx_busy,
  output logic               timeout_err
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, RECONF} state_t;
  state_t state, state_n;
  logic [PW-1:0] own, own_n, rr_ptr, rr_n, pick, own_inc;
  logic [N_REQ-1:0] grant_n;
  logic lock, lock_n, rc, cnt, fire;
  logic [TW-1:0] timer;
  logic [7:0] data_q;
  logic [2:0] cfg_val;
  function automatic logic [PW-1:0] wrap(input int s);
    return PW'(s >= N_REQ ? s - N_REQ : s);
  endfunction
  assign own_inc = wrap(int'(own) + 1);
  assign cnt = (state == WAIT_START && !tx_busy) || (state == IDLE && lock && !req_valid[own]);
  assign fire = cnt && timer == TW'(BUSY_TIMEOUT - 1);
  assign timeout_err = fire && !reset;
  assign tx_wr = state == LOAD;
  assign req_ready = tx_wr ? grant : '0;
  assign tx_data = tx_wr ? req_data[8*own +: 8] : data_q;
  assign tx_en = !reset && state != RECONF;
  always_comb begin
    pick = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(rr_ptr) + k)]) pick = wrap(int'(rr_ptr) + k);
  end
  always_comb begin
    state_n = state;
    own_n = own;
    rr_n = rr_ptr;
    grant_n = grant;
    lock_n = lock;
    if (fire) begin
      state_n = IDLE;
      lock_n = 1'b0;
      grant_n = '0;
      rr_n = own_inc;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_pending && !lock) state_n = RECONF;
          else if (lock) state_n = req_valid[own] ? LOAD : IDLE;
          else if (|req_valid) begin
            state_n = LOAD;
            own_n = pick;
            grant_n = N_REQ'(1) << pick;
          end
        end
        LOAD: begin
          lock_n = !req_last[own];
          state_n = WAIT_START;
        end
        WAIT_START: state_n = tx_busy ? WAIT_DONE : WAIT_START;
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_n = IDLE;
            grant_n = lock ? grant : '0;
            rr_n = lock ? rr_ptr : own_inc;
          end
        end
        RECONF: state_n = rc ? IDLE : RECONF;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      own <= '0;
      rr_ptr <= '0;
      grant <= '0;
      lock <= 1'b0;
      rc <= 1'b0;
      timer <= '0;
      data_q <= '0;
      baud_select <= DEFAULT_BAUD;
      cfg_val <= DEFAULT_BAUD;
      cfg_pending <= 1'b0;
    end else begin
      state <= state_n;
      own <= own_n;
      rr_ptr <= rr_n;
      grant <= grant_n;
      lock <= lock_n;
      rc <= state == RECONF && !rc;
      timer <= cnt && !fire ? timer + 1'b1 : '0;
      if (tx_wr) data_q <= tx_data;
      if (state == RECONF && !rc) baud_select <= cfg_val;
      if (cfg_wr) cfg_val <= cfg_baud;
      cfg_pending <= cfg_wr || (cfg_pending && !(state == RECONF && rc && cfg_val == baud_select));
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_transmitter` instance between `N_REQ` byte producers and owns the transmitter's configuration. It accepts one byte at a time from the granted requester, presents it on the transmitter's data/write inputs, and tracks the transmitter's busy flag through the whole frame. Multi-byte packets keep the grant until their last byte. Baud-rate changes are applied only between packets. The block sits between the system's message sources and the transmitter; the transmitter's `Tx_DATA`, `Tx_WR`, `Tx_EN`, `baud_select` and `Tx_BUSY` connect directly to this block.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, default 4096: clk cycles allowed for busy to rise after a write, and for a locked owner's next byte.
- `DEFAULT_BAUD`, default 3'b111: `baud_select` value after reset.

Ports:
- `clk` in 1: single clock. Everything is synchronous to its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: requester i has a byte.
- `req_data` in 8*N_REQ: requester i byte in bits [8i+7:8i].
- `req_last` in N_REQ: the byte offered by i ends its packet.
- `req_ready` out N_REQ: one-hot, one-cycle accept. The byte is consumed in that cycle.
- `grant` out N_REQ: one-hot current owner; 0 when none.
- `cfg_wr` in 1, `cfg_baud` in 3: request a baud change.
- `cfg_pending` out 1: a baud change is waiting to be applied.
- `tx_en` out 1, `tx_wr` out 1, `tx_data` out 8, `baud_select` out 3: drive the transmitter.
- `tx_busy` in 1: transmitter busy flag.
- `timeout_err` out 1: one-cycle pulse on any timeout.

## Operation
- State machine: IDLE, LOAD, WAIT_START, WAIT_DONE, RECONF.
- **IDLE**
  - Priority 1: if `cfg_pending` and no lock → RECONF.
  - Priority 2: else if lock held and `req_valid[owner]` → LOAD.
  - Priority 3: else if no lock and any `req_valid` → pick the first valid index searching upward from `rr_ptr`, modulo N_REQ; register `grant`; → LOAD.
  - While lock held and the owner is not valid, count cycles. At BUSY_TIMEOUT: pulse `timeout_err`, drop the lock, clear `grant`, set `rr_ptr` = owner+1.
- **LOAD** (one cycle)
  - `tx_data` <= `req_data[owner]`.
  - `tx_wr`=1 and `req_ready[owner]`=1 for this cycle only.
  - lock <= ~`req_last[owner]`.
  - Clear the timer → WAIT_START.
- **WAIT_START**: wait for `tx_busy`=1 → WAIT_DONE. At BUSY_TIMEOUT cycles: pulse `timeout_err`, drop the lock, clear `grant`, `rr_ptr` = owner+1 → IDLE.
- **WAIT_DONE**: wait for `tx_busy`=0 → IDLE. If no lock, clear `grant` and set `rr_ptr` = owner+1 modulo N_REQ in the same transition. WAIT_DONE has no timeout.
- **RECONF** (two cycles)
  - Cycle 1: `tx_en`=0, `baud_select` <= pending value.
  - Cycle 2: `tx_en`=0, clear `cfg_pending` → IDLE.
- Config register: `cfg_wr` sets `cfg_pending` and stores `cfg_baud` in any state. A later `cfg_wr` before application overwrites the stored value (last wins). A `cfg_wr` in the same cycle RECONF clears pending re-arms pending with the new value.
- `tx_data` holds its last value outside LOAD. `tx_wr` is never high for two consecutive cycles.
- An owner that drops `req_valid` mid-packet keeps the lock and is subject to the timeout above.

## Timing
- Reset values:
  - `grant`=0, `req_ready`=0, `tx_wr`=0, `tx_data`=0.
  - `tx_en`=0 while reset is high, 1 from the first cycle after reset.
  - `baud_select`=DEFAULT_BAUD.
  - `cfg_pending`=0, `timeout_err`=0, `rr_ptr`=0, lock=0, state=IDLE.
- Latency: valid seen in IDLE at cycle t → `grant` at t+1, `req_ready`/`tx_wr` at t+1 (LOAD), busy expected from t+2.
- Back-to-back: next LOAD is no earlier than 2 cycles after `tx_busy` falls (WAIT_DONE→IDLE→LOAD).
- Simultaneous events:
  - `cfg_wr` and `req_valid` in IDLE, unlocked → RECONF first.
  - Several valids → round-robin from `rr_ptr`, ties impossible.
- Reset mid-frame: returns to IDLE next cycle with all reset values. In-flight bytes are neither retried nor re-acknowledged.
- Timer is 13 bits wide for the default; width = clog2(BUSY_TIMEOUT)+1. Timeout fires when count == BUSY_TIMEOUT-1.

## Test plan
- Single byte: req 0 sends 8'hA5 with `req_last`=1 → one `req_ready[0]` pulse, one `tx_wr` pulse with `tx_data`=8'hA5; `grant` returns to 0 after busy falls; `rr_ptr`=1.
- Fairness: all four requesters continuously valid with `req_last`=1 → grant order 0,1,2,3,0; no `tx_wr` while `tx_busy`=1.
- Packet lock: req 2 sends 3 bytes (last on 3rd) while req 1 is valid → 3 consecutive frames for req 2, then req 3 or 1 per pointer; req 1 is never granted mid-packet.
- Baud change: `cfg_wr` with 3'b010 during a locked packet → `baud_select` unchanged until the packet ends; then 2 cycles of `tx_en`=0; `baud_select`=3'b010; `cfg_pending` clears.
- Timeout: hold `tx_busy`=0 after a write → `timeout_err` pulses at BUSY_TIMEOUT cycles; `grant`=0; the next requester is served.
- Reset mid-frame: assert `reset` during WAIT_DONE → next cycle all outputs at reset values, `baud_select`=3'b111.
